// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer driving one shared full-adder cell.
// The operands are added LSB first, one bit per clock, over WIDTH cycles.
// The result is presented as registered Sum/Cout, together with a one-cycle Done pulse.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             FA_A,
  output logic             FA_B,
  output logic             FA_Cin,
  input  logic             FA_S,
  input  logic             FA_Cout
);

  // The counter only needs to reach WIDTH-1. It keeps at least one bit so that WIDTH=1 stays legal.
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, a_sr_nxt;
  logic [WIDTH-1:0] b_sr, b_sr_nxt;
  logic [WIDTH-1:0] sum_sr, sum_sr_nxt;
  logic             carry, carry_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] sum_nxt;
  logic             cout_nxt;
  logic             done_nxt;
  logic [WIDTH-1:0] sum_shift;

  // Shift the returned sum bit in at the MSB. This form also works when WIDTH=1.
  assign sum_shift = WIDTH'({FA_S, sum_sr} >> 1);

  // Busy and the adder drive decode from the state register, so they are glitch-free per cycle.
  assign Busy   = (state == RUN);
  assign FA_A   = (state == RUN) & a_sr[0];
  assign FA_B   = (state == RUN) & b_sr[0];
  assign FA_Cin = (state == RUN) & carry;

  // State and datapath registers. Reset is synchronous and clears everything, including the result.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      Sum    <= '0;
      Cout   <= 1'b0;
      Done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      a_sr   <= a_sr_nxt;
      b_sr   <= b_sr_nxt;
      sum_sr <= sum_sr_nxt;
      carry  <= carry_nxt;
      cnt    <= cnt_nxt;
      Sum    <= sum_nxt;
      Cout   <= cout_nxt;
      Done   <= done_nxt;
    end
  end

  // Next-state and datapath sequencing: load in IDLE, then step one bit per cycle in RUN.
  always_comb begin
    state_nxt  = state;
    a_sr_nxt   = a_sr;
    b_sr_nxt   = b_sr;
    sum_sr_nxt = sum_sr;
    carry_nxt  = carry;
    cnt_nxt    = cnt;
    sum_nxt    = Sum;
    cout_nxt   = Cout;
    done_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (Start) begin
          a_sr_nxt  = A;
          b_sr_nxt  = B;
          carry_nxt = Cin;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        sum_sr_nxt = sum_shift;
        carry_nxt  = FA_Cout;
        a_sr_nxt   = a_sr >> 1;
        b_sr_nxt   = b_sr >> 1;
        cnt_nxt    = cnt + CW'(1);
        if (cnt == LAST_BIT) begin
          sum_nxt   = sum_shift;
          cout_nxt  = FA_Cout;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: the bench checks serial_add_ctrl against plain A+B+Cin arithmetic.
// It models the shared full-adder cell and drives directed and random operations.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         fa_a;
  logic         fa_b;
  logic         fa_cin;
  logic         fa_s;
  logic         fa_cout;

  int           n_checks;
  int           n_fails;
  logic [W-1:0] exp_sum;
  logic         exp_cout;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .Clk    (clk),
    .Rst    (rst),
    .Start  (start),
    .A      (a_in),
    .B      (b_in),
    .Cin    (cin),
    .Busy   (busy),
    .Done   (done),
    .Sum    (sum),
    .Cout   (cout),
    .FA_A   (fa_a),
    .FA_B   (fa_b),
    .FA_Cin (fa_cin),
    .FA_S   (fa_s),
    .FA_Cout(fa_cout)
  );

  // The external full-adder cell.
  assign {fa_cout, fa_s} = 2'(fa_a) + 2'(fa_b) + 2'(fa_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Carry into bit k of a+b+c is the overflow of the lower k bits.
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic c, input int k);
    logic [63:0] mask;
    logic [63:0] part;
    mask = (64'd1 << k) - 64'd1;
    part = (64'(a) & mask) + (64'(b) & mask) + 64'(c);
    return part[k];
  endfunction

  // One addition. This task is called at a negedge; it asserts Start immediately.
  // junk_k >= 0 pulses a second Start during RUN. keep=1 leaves the task on the Done
  // cycle so that the next call can start back-to-back.
  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input int junk_k, input bit keep);
    logic [W:0] want;
    int         k;
    int         busy_cnt;
    want  = (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    cin   = c;
    @(negedge clk);
    check("accept_busy", 64'(busy), 64'd1);
    k        = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && k < int'(W) + 4) begin
      if (busy === 1'b1) busy_cnt++;
      if (k < int'(W)) begin
        check("fa_a_bit", 64'(fa_a), 64'(a[k]));
        check("fa_b_bit", 64'(fa_b), 64'(b[k]));
        check("fa_cin_bit", 64'(fa_cin), 64'(carry_into(a, b, c, k)));
      end
      if (k == int'(W) / 2) check("sum_hold", 64'({cout, sum}), 64'({exp_cout, exp_sum}));
      start = (k == junk_k);
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      cin   = 1'($urandom);
      @(negedge clk);
      k++;
    end
    check("done_seen", 64'(done), 64'd1);
    check("latency", 64'(k), 64'(W));
    check("busy_cycles", 64'(busy_cnt), 64'(W));
    check("busy_low_on_done", 64'(busy), 64'd0);
    check("result", 64'({cout, sum}), 64'(want));
    exp_sum  = want[W-1:0];
    exp_cout = want[W];
    if (!keep) begin
      start = 1'b0;
      @(negedge clk);
      check("done_one_cycle", 64'(done), 64'd0);
      check("idle_after", 64'(busy), 64'd0);
      check("fa_idle", 64'({fa_a, fa_b, fa_cin}), 64'd0);
      check("result_held", 64'({cout, sum}), 64'(want));
    end
  endtask

  initial begin
    int  dones;
    int  junk;
    bit  keep;
    n_checks = 0;
    n_fails  = 0;
    exp_sum  = '0;
    exp_cout = 1'b0;
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    cin   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'({cout, sum}), 64'd0);
    check("rst_fa", 64'({fa_a, fa_b, fa_cin}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    run_add(8'h5A, 8'h3C, 1'b0, -1, 1'b0);
    run_add(8'hFF, 8'h01, 1'b0, -1, 1'b0);
    run_add(8'hFF, 8'h00, 1'b1, -1, 1'b0);
    run_add(8'h12, 8'h34, 1'b0, 2, 1'b0);
    run_add(8'h10, 8'h20, 1'b0, -1, 1'b1);
    run_add(8'h01, 8'h02, 1'b1, -1, 1'b0);

    // Reset during RUN cycle 4.
    start = 1'b1;
    a_in  = 8'hAB;
    b_in  = 8'hCD;
    cin   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_result", 64'({cout, sum}), 64'd0);
    check("midrst_fa", 64'({fa_a, fa_b, fa_cin}), 64'd0);
    exp_sum  = '0;
    exp_cout = 1'b0;
    dones    = 0;
    for (int i = 0; i < int'(W) + 2; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("midrst_no_done", 64'(dones), 64'd0);
    run_add(8'h03, 8'h04, 1'b0, -1, 1'b0);

    // Reset and Start together: the reset wins.
    rst   = 1'b1;
    start = 1'b1;
    a_in  = 8'h77;
    b_in  = 8'h11;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start_busy", 64'(busy), 64'd0);
    check("rst_start_result", 64'({cout, sum}), 64'd0);
    @(negedge clk);
    check("rst_start_still_idle", 64'(busy), 64'd0);
    exp_sum  = '0;
    exp_cout = 1'b0;

    // Random operations, with occasional ignored Starts and back-to-back requests.
    for (int i = 0; i < 30; i++) begin
      junk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, W - 2)) : -1;
      keep = (i != 29) && ($urandom_range(0, 3) == 0);
      run_add(W'($urandom), W'($urandom), 1'($urandom), junk, keep);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial addition sequencer that time-shares one external `Full_Adder` cell to add two WIDTH-bit operands, one bit per clock, LSB first. It latches the operands on a start request and steps the adder through WIDTH cycles, keeping the running carry in a flip-flop. It then presents a registered sum and carry-out with a one-cycle done pulse. It sits between the convolution datapath's operand source and the single shared full-adder instance, trading latency for area.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits; legal range is 1 to 32.

Ports:
- Clk  input  1  system clock. Rising-edge only.
- Rst  input  1  reset. Synchronous and active-high.
- Start  input  1  request to begin an addition. Sampled only when Busy=0.
- A  input  WIDTH  operand A. Captured on an accepted Start.
- B  input  WIDTH  operand B. Captured on an accepted Start.
- Cin  input  1  initial carry-in. Captured on an accepted Start.
- Busy  output  1  high while an addition is in progress (RUN state).
- Done  output  1  one-cycle pulse when Sum and Cout become valid.
- Sum  output  WIDTH  registered result. Holds until the next completion.
- Cout  output  1  registered final carry. Holds until the next completion.
- FA_A  output  1  bit driven to the shared full adder's A input.
- FA_B  output  1  bit driven to the shared full adder's B input.
- FA_Cin  output  1  carry driven to the shared full adder's Cin input.
- FA_S  input  1  sum bit returned by the shared full adder.
- FA_Cout  input  1  carry returned by the shared full adder.

## Operation
- **States:**
  - IDLE (Busy=0).
  - RUN (Busy=1).
- **Internal state:**
  - shift registers a_sr and b_sr, each WIDTH bits.
  - sum_sr, WIDTH bits.
  - carry flip-flop.
  - bit counter cnt, with enough bits to count to WIDTH-1.
- **IDLE, Start=1:**
  - a_sr<=A, b_sr<=B, carry<=Cin, cnt<=0.
  - go to RUN.
- **IDLE, Start=0:** hold all state.
- **RUN, each edge:**
  - sum_sr <= {FA_S, sum_sr[WIDTH-1:1]}.
  - carry <= FA_Cout.
  - a_sr and b_sr shift right by 1.
  - cnt <= cnt+1.
- **RUN, edge with cnt==WIDTH-1:**
  - Sum <= {FA_S, sum_sr[WIDTH-1:1]}, Cout <= FA_Cout, Done <= 1.
  - go to IDLE.
- **FA drive (combinational):**
  - in RUN: FA_A=a_sr[0], FA_B=b_sr[0], FA_Cin=carry.
  - in IDLE: all three are 0.
- Start while Busy=1 is ignored. No queuing, and in-flight operands are unaffected.
- A, B and Cin changing during RUN have no effect on the result.
- **Arithmetic:** {Cout,Sum} = A + B + Cin, exact. No overflow flag is produced; Cout carries the overflow.
- WIDTH=1 completes in a single RUN cycle.

## Timing
- **Reset values:**
  - state=IDLE.
  - Busy=0, Done=0, Sum=0, Cout=0.
  - FA_A=FA_B=FA_Cin=0.
  - a_sr, b_sr, sum_sr, carry and cnt all 0.
- **Edge numbering:** Start is sampled high at edge E0 with Busy=0.
- Busy is high from E0 through EW, i.e. exactly WIDTH cycles.
- Bit i is presented to the full adder between edges E_i and E_{i+1}, and its result is captured at E_{i+1}.
- Sum, Cout and Done update at EW. Done is high for exactly one cycle, E_W to E_{W+1}.
- **Latency:** WIDTH cycles from Start acceptance to Done.
- **Throughput:** one addition per WIDTH cycles.
- **Back-to-back:** Start high during the Done cycle is accepted, because Busy is already 0.
  - Sum and Cout then hold the previous result until the new Done.
- The FA_S and FA_Cout combinational path must settle within one Clk period.
- **Rst mid-operation:**
  - aborts with no Done.
  - Sum and Cout are cleared to 0.
  - state returns to IDLE at that edge.
- **Rst and Start in the same cycle:** Rst wins; nothing is captured.

## Test plan
- **Basic add.** WIDTH=8; A=0x5A, B=0x3C, Cin=0, one-cycle Start.
  - Busy is high for 8 cycles.
  - Done pulses once, 8 cycles after acceptance.
  - Sum=0x96, Cout=0.
- **Full carry ripple.** A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1.
- **Initial carry.** A=0xFF, B=0x00, Cin=1 -> Sum=0x00, Cout=1.
- **Start while busy.** Pulse Start again with different operands at cycle 3 of RUN.
  - The second request is ignored.
  - The first result is correct.
  - Exactly one Done pulse occurs.
- **Back-to-back.**
  - First request A=0x10, B=0x20, Cin=0.
  - Hold Start high into the Done cycle with A=0x01, B=0x02, Cin=1.
  - Expected: first Done gives Sum=0x30.
  - The second operation starts immediately, and its Done arrives 8 cycles later with Sum=0x04.
- **Reset mid-operation.** Assert Rst at RUN cycle 4.
  - Next cycle: Busy=0, Sum=0, Cout=0, and FA outputs are 0.
  - No Done pulse occurs.
  - A following Start with A=0x03, B=0x04, Cin=0 gives Sum=0x07.
